// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: instruction fields, ALU op encodings, control states, trap causes.
// Used by the control FSM, the ALU and the data path.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SHIFT = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic CAUSE_ILLEGAL     = 1'b0;
  localparam logic CAUSE_MEM_TIMEOUT = 1'b1;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational instruction decoder: op/funct to ALU controls plus a legality flag.
// Anything not in the supported instruction set reports legal = 0.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [2:0] opcode,
  output logic       direction,
  output logic       alu_src,
  output logic       legal
);

  always_comb begin
    opcode    = ALU_ADD;
    direction = 1'b0;
    alu_src   = 1'b0;
    legal     = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD: opcode = ALU_ADD;
          FN_SUB: opcode = ALU_SUB;
          FN_AND: opcode = ALU_AND;
          FN_OR:  opcode = ALU_OR;
          FN_SLT: opcode = ALU_SLT;
          FN_SLL: opcode = ALU_SHIFT;
          FN_SRL: begin
            opcode    = ALU_SHIFT;
            direction = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_src = 1'b1;
      OP_BEQ: opcode = ALU_SUB;
      OP_J: begin
        opcode = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, waits on data memory with a
// timeout, traps on illegal instructions and counts retired instructions.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instruction_op,
  input  logic [5:0]       instruction_fn,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             Reg_write,
  output logic             Alu_Src,
  output logic             direction,
  output logic [2:0]       opcode,
  output logic             mem_read,
  output logic             mem_write,
  output logic             MEMTOREG,
  output logic             branch,
  output logic             jump,
  output logic             pc_en,
  output logic             ir_en,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  ctrl_state_t       state_q, state_d;
  logic [5:0]        op_q, op_d, fn_q, fn_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              trap_q, trap_d, cause_q, cause_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [5:0] dec_op, dec_fn;
  logic [2:0] dec_opcode;
  logic       dec_direction, dec_alu_src, dec_legal;
  logic       alu_active;

  // DECODE must judge the live instruction; every later state uses the captured copy.
  assign dec_op = (state_q == DECODE) ? instruction_op : op_q;
  assign dec_fn = (state_q == DECODE) ? instruction_fn : fn_q;

  mips_alu_decoder u_alu_decoder (
    .op        (dec_op),
    .fn        (dec_fn),
    .opcode    (dec_opcode),
    .direction (dec_direction),
    .alu_src   (dec_alu_src),
    .legal     (dec_legal)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fn_d       = fn_q;
    wait_cnt_d = wait_cnt_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    alu_active = 1'b0;
    RegDst     = 1'b0;
    Reg_write  = 1'b0;
    Alu_Src    = 1'b0;
    direction  = 1'b0;
    opcode     = 3'b000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    MEMTOREG   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    pc_en      = 1'b0;
    ir_en      = 1'b0;

    case (state_q)
      FETCH: begin
        ir_en   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        op_d = instruction_op;
        fn_d = instruction_fn;
        if (!dec_legal) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else if (instruction_op == OP_J) begin
          jump    = 1'b1;
          pc_en   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_active = 1'b1;
        if (op_q == OP_BEQ) begin
          branch  = 1'b1;
          pc_en   = 1'b1;
          state_d = FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          wait_cnt_d = '0;
          state_d    = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        alu_active = 1'b1;
        mem_read   = (op_q == OP_LW);
        mem_write  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_MEM_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      WB: begin
        alu_active = 1'b1;
        Reg_write  = 1'b1;
        pc_en      = 1'b1;
        RegDst     = (op_q == OP_RTYPE);
        MEMTOREG   = (op_q == OP_LW);
        state_d    = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase

    if (alu_active) begin
      opcode    = dec_opcode;
      direction = dec_direction;
      Alu_Src   = dec_alu_src;
    end

    // Hold every strobe low while reset is asserted so nothing leaks out before the edge lands.
    if (!rst_n) begin
      RegDst    = 1'b0;
      Reg_write = 1'b0;
      Alu_Src   = 1'b0;
      direction = 1'b0;
      opcode    = 3'b000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      MEMTOREG  = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      pc_en     = 1'b0;
      ir_en     = 1'b0;
    end

    retired_d = pc_en ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      op_q       <= '0;
      fn_q       <= '0;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      fn_q       <= fn_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      retired_q  <= retired_d;
    end
  end

  assign trap          = trap_q;
  assign trap_cause    = cause_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle
// against hand-computed control vectors, plus timeout, illegal-op and reset cases.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  instruction_op, instruction_fn;
  logic        mem_ready;
  logic        RegDst, Reg_write, Alu_Src, direction;
  logic [2:0]  opcode;
  logic        mem_read, mem_write, MEMTOREG, branch, jump, pc_en, ir_en, trap, trap_cause;
  logic [31:0] instr_retired;
  logic [15:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_fsm #(.MEM_WAIT_MAX(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_op(instruction_op), .instruction_fn(instruction_fn),
    .mem_ready(mem_ready), .RegDst(RegDst), .Reg_write(Reg_write), .Alu_Src(Alu_Src),
    .direction(direction), .opcode(opcode), .mem_read(mem_read), .mem_write(mem_write),
    .MEMTOREG(MEMTOREG), .branch(branch), .jump(jump), .pc_en(pc_en), .ir_en(ir_en),
    .trap(trap), .trap_cause(trap_cause), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  assign ctrl = {RegDst, Reg_write, Alu_Src, direction, opcode, mem_read, mem_write,
                 MEMTOREG, branch, jump, pc_en, ir_en, trap, trap_cause};

  // Field order: RegDst Reg_write Alu_Src direction opcode[2:0] mem_read mem_write
  //              MEMTOREG branch jump pc_en ir_en trap trap_cause
  function automatic logic [15:0] ev(input logic rd, input logic rw, input logic as, input logic dr,
                                     input logic [2:0] op, input logic mr, input logic mw,
                                     input logic mt, input logic br, input logic jp, input logic pc,
                                     input logic ir, input logic tr, input logic tc);
    return {rd, rw, as, dr, op, mr, mw, mt, br, jp, pc, ir, tr, tc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] v_zero, v_fetch, v_trap_ill, v_trap_mem;
  logic [5:0]  r_fn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
  logic [2:0]  r_opc [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b011};
  logic        r_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    v_zero     = 16'h0000;
    v_fetch    = ev(0,0,0,0,3'b000,0,0,0,0,0,0,1,0,0);
    v_trap_ill = ev(0,0,0,0,3'b000,0,0,0,0,0,0,0,1,0);
    v_trap_mem = ev(0,0,0,0,3'b000,0,0,0,0,0,0,0,1,1);

    rst_n = 1'b0; instruction_op = 6'h00; instruction_fn = 6'h00; mem_ready = 1'b0;
    step(); step();
    chk("reset_ctrl", {16'h0, ctrl}, {16'h0, v_zero});
    chk("reset_retired", instr_retired, 32'd0);
    rst_n = 1'b1; #1;
    chk("post_reset_fetch", {16'h0, ctrl}, {16'h0, v_fetch});

    // R-type sweep: 4 cycles each, retired count steps once per instruction
    for (int i = 0; i < 7; i++) begin
      instruction_op = 6'h00; instruction_fn = r_fn[i]; #1;
      chk($sformatf("r%0d_fetch", i), {16'h0, ctrl}, {16'h0, v_fetch});
      step();
      chk($sformatf("r%0d_decode", i), {16'h0, ctrl}, {16'h0, v_zero});
      step();
      chk($sformatf("r%0d_exec", i), {16'h0, ctrl},
          {16'h0, ev(0,0,0,r_dir[i],r_opc[i],0,0,0,0,0,0,0,0,0)});
      step();
      chk($sformatf("r%0d_wb", i), {16'h0, ctrl},
          {16'h0, ev(1,1,0,r_dir[i],r_opc[i],0,0,0,0,0,1,0,0,0)});
      step();
      chk($sformatf("r%0d_retired", i), instr_retired, i + 1);
    end

    // lw with mem_ready on third MEM cycle
    instruction_op = 6'h23; instruction_fn = 6'h00; #1;
    chk("lw_fetch", {16'h0, ctrl}, {16'h0, v_fetch});
    step();
    chk("lw_decode", {16'h0, ctrl}, {16'h0, v_zero});
    step();
    chk("lw_exec", {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,0,0,0,0,0,0,0,0,0)});
    for (int m = 0; m < 3; m++) begin
      step();
      if (m == 2) begin mem_ready = 1'b1; #1; end
      chk($sformatf("lw_mem%0d", m), {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,1,0,0,0,0,0,0,0,0)});
    end
    step();
    mem_ready = 1'b0; #1;
    chk("lw_wb", {16'h0, ctrl}, {16'h0, ev(0,1,1,0,3'b010,0,0,1,0,0,1,0,0,0)});
    step();
    chk("lw_retired", instr_retired, 32'd8);

    // beq then j back to back
    instruction_op = 6'h04; #1;
    chk("beq_fetch", {16'h0, ctrl}, {16'h0, v_fetch});
    step();
    chk("beq_decode", {16'h0, ctrl}, {16'h0, v_zero});
    step();
    chk("beq_exec", {16'h0, ctrl}, {16'h0, ev(0,0,0,0,3'b110,0,0,0,1,0,1,0,0,0)});
    step();
    instruction_op = 6'h02; #1;
    chk("j_fetch", {16'h0, ctrl}, {16'h0, v_fetch});
    chk("beq_retired", instr_retired, 32'd9);
    step();
    chk("j_decode", {16'h0, ctrl}, {16'h0, ev(0,0,0,0,3'b000,0,0,0,0,1,1,0,0,0)});
    step();
    chk("j_retired", instr_retired, 32'd10);
    chk("j_back_fetch", {16'h0, ctrl}, {16'h0, v_fetch});

    // addi
    instruction_op = 6'h08; #1;
    step();
    chk("addi_decode", {16'h0, ctrl}, {16'h0, v_zero});
    step();
    chk("addi_exec", {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,0,0,0,0,0,0,0,0,0)});
    step();
    chk("addi_wb", {16'h0, ctrl}, {16'h0, ev(0,1,1,0,3'b010,0,0,0,0,0,1,0,0,0)});
    step();
    chk("addi_retired", instr_retired, 32'd11);

    // sw completing on the first MEM cycle
    instruction_op = 6'h2B; #1;
    step(); step(); step();
    mem_ready = 1'b1; #1;
    chk("sw_mem_ready", {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,0,1,0,0,0,1,0,0,0)});
    step();
    mem_ready = 1'b0; #1;
    chk("sw_back_fetch", {16'h0, ctrl}, {16'h0, v_fetch});
    chk("sw_retired", instr_retired, 32'd12);

    // mem_ready outside MEM is ignored
    mem_ready = 1'b1; instruction_op = 6'h00; instruction_fn = 6'h20; #1;
    step(); step();
    chk("ready_ignored_exec", {16'h0, ctrl}, {16'h0, ev(0,0,0,0,3'b010,0,0,0,0,0,0,0,0,0)});
    step();
    mem_ready = 1'b0; #1;
    chk("ready_ignored_wb", {16'h0, ctrl}, {16'h0, ev(1,1,0,0,3'b010,0,0,0,0,0,1,0,0,0)});
    step();

    // Reset during lw MEM
    instruction_op = 6'h23; #1;
    step(); step(); step();
    chk("rst_lw_mem", {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,1,0,0,0,0,0,0,0,0)});
    rst_n = 1'b0; #1;
    chk("rst_lw_gated", {16'h0, ctrl}, {16'h0, v_zero});
    step();
    chk("rst_lw_ctrl", {16'h0, ctrl}, {16'h0, v_zero});
    chk("rst_lw_retired", instr_retired, 32'd0);
    instruction_op = 6'h3F; rst_n = 1'b1; #1;
    chk("rst_lw_fetch", {16'h0, ctrl}, {16'h0, v_fetch});

    // Illegal opcode 0x3F
    step();
    chk("ill_decode", {16'h0, ctrl}, {16'h0, v_zero});
    step();
    chk("ill_trap", {16'h0, ctrl}, {16'h0, v_trap_ill});
    mem_ready = 1'b1;
    step(); step();
    chk("ill_trap_sticky", {16'h0, ctrl}, {16'h0, v_trap_ill});
    chk("ill_retired", instr_retired, 32'd0);
    mem_ready = 1'b0;

    rst_n = 1'b0;
    step();
    chk("ill_reset_ctrl", {16'h0, ctrl}, {16'h0, v_zero});
    chk("ill_reset_retired", instr_retired, 32'd0);

    // Illegal R-type funct
    instruction_op = 6'h00; instruction_fn = 6'h21; rst_n = 1'b1; #1;
    step(); step();
    chk("ill_fn_trap", {16'h0, ctrl}, {16'h0, v_trap_ill});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; #1;
    chk("ill_fn_cleared", {16'h0, ctrl}, {16'h0, v_fetch});

    // sw with mem_ready never: 16 MEM cycles then timeout trap
    instruction_op = 6'h2B; instruction_fn = 6'h00; mem_ready = 1'b0; #1;
    step(); step();
    for (int m = 0; m < 16; m++) begin
      step();
      chk($sformatf("sw_wait%0d", m), {16'h0, ctrl}, {16'h0, ev(0,0,1,0,3'b010,0,1,0,0,0,0,0,0,0)});
    end
    step();
    chk("sw_timeout_trap", {16'h0, ctrl}, {16'h0, v_trap_mem});
    mem_ready = 1'b1;
    step();
    chk("sw_timeout_sticky", {16'h0, ctrl}, {16'h0, v_trap_mem});
    chk("sw_timeout_retired", instr_retired, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
